// File: rtl/motor_drive_ctrl_if.sv
// Control/status bundle between the motor drive controller and its environment.
interface motor_drive_ctrl_if;
  logic       enable;
  logic       col_ok;
  logic       pwm_l;
  logic       pwm_r;
  logic       dir_l;
  logic       dir_r;
  logic [2:0] state;
  logic       fault;

  modport master (output enable, col_ok,
                  input  pwm_l, pwm_r, dir_l, dir_r, state, fault);
  modport slave  (input  enable, col_ok,
                  output pwm_l, pwm_r, dir_l, dir_r, state, fault);
endinterface

// File: rtl/motor_drive_ctrl.sv
// Motor drive FSM: forward drive, brake/reverse/pivot avoidance with bounded retry, and PWM.
// Optional soft-start duty ramp in FWD is enabled by defining SOFT_START_EN.
//
// state   | meaning
// STOP    | idle, pwm 0, dirs forward; waits for enable, clear path, no fault
// FWD     | forward drive at DUTY_FWD
// BRAKE   | pwm 0, dirs held, BRAKE_CYCLES dwell
// REVERSE | both wheels back at DUTY_MAN, REVERSE_CYCLES dwell
// TURN    | pivot (left fwd, right back) at DUTY_MAN, TURN_CYCLES dwell
module motor_drive_ctrl #(
  parameter int unsigned PWM_PERIOD     = 50_000,
  parameter int unsigned DUTY_FWD       = 37_500,
  parameter int unsigned DUTY_MAN       = 25_000,
  parameter int unsigned BRAKE_CYCLES   = 5_000_000,
  parameter int unsigned REVERSE_CYCLES = 25_000_000,
  parameter int unsigned TURN_CYCLES    = 15_000_000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RAMP_STEP      = 2_500
) (
  input logic               clk,
  input logic               rst,
  motor_drive_ctrl_if.slave bus
);

`ifdef SOFT_START_EN
  localparam bit SOFT_START = 1'b1;
`else
  localparam bit SOFT_START = 1'b0;
`endif

  localparam int unsigned DWELL_MAX = (BRAKE_CYCLES > REVERSE_CYCLES) ?
                                      ((BRAKE_CYCLES > TURN_CYCLES) ? BRAKE_CYCLES : TURN_CYCLES) :
                                      ((REVERSE_CYCLES > TURN_CYCLES) ? REVERSE_CYCLES : TURN_CYCLES);
  localparam int unsigned DUTY_MAX  = (DUTY_FWD > DUTY_MAN) ? DUTY_FWD : DUTY_MAN;
  localparam int unsigned CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned TW = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
  localparam int unsigned DW = (DUTY_MAX > 0) ? $clog2(DUTY_MAX + 1) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    ST_STOP    = 3'd0,
    ST_FWD     = 3'd1,
    ST_BRAKE   = 3'd2,
    ST_REVERSE = 3'd3,
    ST_TURN    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_last;
  logic [RW-1:0]   retry_q, retry_d, retry_inc;
  logic            fault_q, fault_d;
  logic            dir_l_q, dir_l_d, dir_r_q, dir_r_d;

  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   duty_active, duty_tgt, ramp_next;
  logic [31:0]     ramp_sum;
  logic            wrap, drive, pwm_q;

  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    timer_last = '0;
    case (state_q)
      ST_FWD, ST_TURN: timer_last = TW'(TURN_CYCLES - 1);
      ST_BRAKE:        timer_last = TW'(BRAKE_CYCLES - 1);
      ST_REVERSE:      timer_last = TW'(REVERSE_CYCLES - 1);
      default:         timer_last = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fault_d = fault_q;
    timer_d = timer_q;
    dir_l_d = dir_l_q;
    dir_r_d = dir_r_q;

    if (!bus.enable) begin
      state_d = ST_STOP;
      retry_d = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        ST_STOP:    if (bus.col_ok && !fault_q) state_d = ST_FWD;
        ST_FWD: begin
          if (!bus.col_ok)                state_d = ST_BRAKE;
          else if (timer_q == timer_last) retry_d = '0;
        end
        ST_BRAKE:   if (timer_q == timer_last) state_d = ST_REVERSE;
        ST_REVERSE: if (timer_q == timer_last) state_d = ST_TURN;
        ST_TURN: begin
          if (timer_q == timer_last) begin
            retry_d = retry_inc;
            if (bus.col_ok)                      state_d = ST_FWD;
            else if (32'(retry_inc) < MAX_RETRY) state_d = ST_BRAKE;
            else begin
              state_d = ST_STOP;
              fault_d = 1'b1;
            end
          end
        end
        default:    state_d = ST_STOP;
      endcase
    end

    // FWD holds at its terminal value so the retry-clear window stays satisfied
    if (state_d != state_q || !bus.enable) timer_d = '0;
    else if (timer_q != timer_last)        timer_d = timer_q + TW'(1);

    case (state_d)
      ST_STOP, ST_FWD: begin dir_l_d = 1'b1; dir_r_d = 1'b1; end
      ST_REVERSE:      begin dir_l_d = 1'b0; dir_r_d = 1'b0; end
      ST_TURN:         begin dir_l_d = 1'b1; dir_r_d = 1'b0; end
      default:         ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STOP;
      timer_q <= '0;
      retry_q <= '0;
      fault_q <= 1'b0;
      dir_l_q <= 1'b1;
      dir_r_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      dir_l_q <= dir_l_d;
      dir_r_q <= dir_r_d;
    end
  end

  assign wrap     = (cnt_q == CW'(PWM_PERIOD - 1));
  assign drive    = (state_q == ST_FWD) || (state_q == ST_REVERSE) || (state_q == ST_TURN);
  assign ramp_sum = 32'(duty_active) + RAMP_STEP;
  assign ramp_next = (ramp_sum >= DUTY_FWD) ? DW'(DUTY_FWD) : DW'(ramp_sum);

  always_comb begin
    duty_tgt = '0;
    case (state_q)
      ST_FWD:              duty_tgt = SOFT_START ? ramp_next : DW'(DUTY_FWD);
      ST_REVERSE, ST_TURN: duty_tgt = DW'(DUTY_MAN);
      default:             duty_tgt = '0;
    endcase
  end

  // Zeroing the latch in STOP/BRAKE means a manoeuvre never inherits a stale
  // forward duty; the first pulse after entry is always a full one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      duty_active <= '0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CW'(1);
      if (state_q == ST_STOP || state_q == ST_BRAKE)
        duty_active <= '0;
      else if (SOFT_START && state_q != ST_FWD && state_d == ST_FWD)
        duty_active <= '0;
      else if (wrap)
        duty_active <= duty_tgt;
      pwm_q <= drive && (32'(cnt_q) < 32'(duty_active));
    end
  end

  assign bus.pwm_l = pwm_q;
  assign bus.pwm_r = pwm_q;
  assign bus.dir_l = dir_l_q;
  assign bus.dir_r = dir_r_q;
  assign bus.state = state_q;
  assign bus.fault = fault_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed + randomized bench for motor_drive_ctrl against a cycle-level reference model.
module tb_motor_drive_ctrl;
  localparam int P     = 10;
  localparam int DF    = 7;
  localparam int DM    = 5;
  localparam int B_CYC = 4;
  localparam int R_CYC = 20;
  localparam int T_CYC = 12;
  localparam int MAXR  = 2;
  localparam int RS    = 3;

`ifdef SOFT_START_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  motor_drive_ctrl_if bus();

  motor_drive_ctrl #(
    .PWM_PERIOD(P), .DUTY_FWD(DF), .DUTY_MAN(DM), .BRAKE_CYCLES(B_CYC),
    .REVERSE_CYCLES(R_CYC), .TURN_CYCLES(T_CYC), .MAX_RETRY(MAXR), .RAMP_STEP(RS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: phase names are the spec's, m_left = cycles remaining in dwell
  int m_st, m_left, m_retry, m_pos, m_duty;
  bit m_fault, m_dl, m_dr, m_pwm;

  function automatic int dwell_of(input int s);
    case (s)
      1: return T_CYC;
      2: return B_CYC;
      3: return R_CYC;
      4: return T_CYC;
      default: return 1;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit en, input bit col);
    int ns, nret, nduty;
    bit nfault, wrap;
    if (r) begin
      m_st = 0; m_left = 1; m_retry = 0; m_fault = 0;
      m_dl = 1; m_dr = 1; m_pos = 0; m_duty = 0; m_pwm = 0;
      return;
    end
    wrap   = (m_pos == P - 1);
    m_pwm  = (m_st == 1 || m_st == 3 || m_st == 4) && (m_pos < m_duty);
    ns     = m_st;
    nret   = m_retry;
    nfault = m_fault;
    if (!en) begin
      ns = 0; nret = 0; nfault = 0;
    end else begin
      case (m_st)
        0: if (col && !m_fault) ns = 1;
        1: if (!col) ns = 2; else if (m_left == 1) nret = 0;
        2: if (m_left == 1) ns = 3;
        3: if (m_left == 1) ns = 4;
        4: if (m_left == 1) begin
             nret = m_retry + 1;
             if (col) ns = 1;
             else if (nret < MAXR) ns = 2;
             else begin ns = 0; nfault = 1; end
           end
        default: ns = 0;
      endcase
    end
    nduty = m_duty;
    if (m_st == 0 || m_st == 2) nduty = 0;
    else if (SOFT && ns == 1 && m_st != 1) nduty = 0;
    else if (wrap) begin
      if (m_st == 1) nduty = SOFT ? ((m_duty + RS > DF) ? DF : m_duty + RS) : DF;
      else nduty = DM;
    end
    if (ns != m_st) m_left = dwell_of(ns);
    else if (m_left > 1) m_left = m_left - 1;
    case (ns)
      0, 1: begin m_dl = 1; m_dr = 1; end
      3:    begin m_dl = 0; m_dr = 0; end
      4:    begin m_dl = 1; m_dr = 0; end
      default: ;
    endcase
    m_st = ns; m_retry = nret; m_fault = nfault; m_duty = nduty;
    m_pos = wrap ? 0 : m_pos + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit en, input bit col);
    rst = r; bus.enable = en; bus.col_ok = col;
    @(posedge clk);
    model_step(r, en, col);
    cyc++;
    #1;
    chk("state", 32'(bus.state), m_st);
    chk("pwm_l", 32'(bus.pwm_l), 32'(m_pwm));
    chk("pwm_r", 32'(bus.pwm_r), 32'(m_pwm));
    chk("dir_l", 32'(bus.dir_l), 32'(m_dl));
    chk("dir_r", 32'(bus.dir_r), 32'(m_dr));
    chk("fault", 32'(bus.fault), 32'(m_fault));
  endtask

  task automatic run_while(input int st, input int lim, output int n);
    n = 0;
    while (int'(bus.state) == st && n < lim) begin
      n++;
      tick(0, 1, 1);
    end
  endtask

  initial begin
    int n, entries, prev, highs, run, pulses, col_len;
    bit rc, re, rcol;
    int exp_ramp [4];
    bus.enable = 1'b0;
    bus.col_ok = 1'b1;
    if (SOFT) exp_ramp = '{3, 6, 7, 7};
    else      exp_ramp = '{7, 7, 7, 7};

    // reset and start
    repeat (3) tick(1, 0, 1);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pwm", 32'(bus.pwm_l), 0);
    chk("rst_dir", 32'({bus.dir_l, bus.dir_r}), 3);
    chk("rst_fault", 32'(bus.fault), 0);
    tick(0, 1, 1);
    chk("start_fwd", 32'(bus.state), 1);
    repeat (40) tick(0, 1, 1);
    highs = 0;
    for (int i = 0; i < P; i++) begin tick(0, 1, 1); highs += int'(bus.pwm_l); end
    chk("fwd_high", highs, DF);

    // single collision
    tick(0, 1, 0);
    chk("brake_entry", 32'(bus.state), 2);
    run_while(2, 50, n); chk("brake_len", n, B_CYC);
    run_while(3, 50, n); chk("reverse_len", n, R_CYC);
    run_while(4, 50, n); chk("turn_len", n, T_CYC);
    chk("back_fwd", 32'(bus.state), 1);

    // retry to fault
    repeat (30) tick(0, 1, 1);
    entries = 0; prev = 1;
    for (int i = 0; i < 300 && int'(bus.state) != 0; i++) begin
      tick(0, 1, 0);
      if (int'(bus.state) == 2 && prev != 2) entries++;
      prev = int'(bus.state);
    end
    chk("manoeuvres", entries, MAXR);
    tick(0, 1, 0);
    chk("fault_state", 32'(bus.state), 0);
    chk("fault_set", 32'(bus.fault), 1);
    chk("fault_pwm", 32'(bus.pwm_l), 0);
    tick(0, 0, 0);
    chk("fault_clr", 32'(bus.fault), 0);
    tick(0, 1, 1);
    chk("reenable_fwd", 32'(bus.state), 1);

    // enable drop at cycle 8 of REVERSE
    repeat (30) tick(0, 1, 1);
    tick(0, 1, 0);
    run_while(2, 50, n);
    repeat (7) tick(0, 1, 1);
    chk("rev_cycle8", 32'(bus.state), 3);
    tick(0, 0, 1);
    chk("drop_stop", 32'(bus.state), 0);
    tick(0, 0, 1);
    chk("drop_pwm", 32'(bus.pwm_l), 0);
    chk("drop_dir", 32'({bus.dir_l, bus.dir_r}), 3);

    // collision at pwm phase 3: manoeuvre pulses must all be full length
    tick(0, 1, 1);
    repeat (40) tick(0, 1, 1);
    for (int i = 0; i < 20 && m_pos != 3; i++) tick(0, 1, 1);
    tick(0, 1, 0);
    run = 0; pulses = 0;
    for (int i = 0; i < 100 && int'(bus.state) != 1; i++) begin
      tick(0, 1, 1);
      if (bus.pwm_l) run++;
      else begin
        if (run != 0) begin chk("pulse_len", run, DM); pulses++; end
        run = 0;
      end
    end
    chk("pulses_seen", 32'(pulses >= 2), 1);

    // per-period high time after entering FWD from STOP
    tick(0, 0, 1);
    for (int i = 0; i < 20 && m_pos != 4; i++) tick(0, 0, 1);
    tick(0, 1, 1);
    chk("ramp_entry", 32'(bus.state), 1);
    highs = 0;
    for (int i = 0; i < 5; i++) begin tick(0, 1, 1); highs += int'(bus.pwm_l); end
    chk("ramp_p0", highs, 0);
    for (int p = 0; p < 4; p++) begin
      highs = 0;
      for (int i = 0; i < P; i++) begin tick(0, 1, 1); highs += int'(bus.pwm_l); end
      chk("ramp_period", highs, exp_ramp[p]);
    end

    // randomized stretch
    col_len = 0; rcol = 1;
    for (int i = 0; i < 3000; i++) begin
      if (col_len == 0) begin
        rcol = ($urandom_range(0, 3) != 0);
        col_len = rcol ? $urandom_range(1, 60) : $urandom_range(1, 120);
      end
      col_len--;
      rc = ($urandom_range(0, 999) < 3);
      re = ($urandom_range(0, 99) < 98);
      tick(rc, re, rcol);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/motor_drive_ctrl.md
# motor_drive_ctrl

Motor drive stage directly downstream of the collision detector. Consumes its registered drive/stop flag (1 = path clear, 0 = collision) and produces PWM and direction signals for the left and right motor drivers. On collision it runs a fixed avoidance manoeuvre of brake, reverse and pivot-turn. It retries a bounded number of times before latching a fault.

## Interface
- `PWM_PERIOD`, default 50_000: PWM period in clk cycles (1 kHz at 50 MHz).
- `DUTY_FWD`, default 37_500: forward high-time in cycles; must be ≤ PWM_PERIOD.
- `DUTY_MAN`, default 25_000: high-time during reverse and turn.
- `BRAKE_CYCLES`, default 5_000_000: brake dwell in cycles.
- `REVERSE_CYCLES`, default 25_000_000: reverse dwell in cycles.
- `TURN_CYCLES`, default 15_000_000: pivot dwell in cycles.
- `MAX_RETRY`, default 3: number of consecutive manoeuvres before fault.
- `RAMP_STEP`, default 2_500: duty increment per PWM period (soft start only).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: 1 = allowed to drive; 0 = stop and clear fault.
- `col_ok` in 1: collision detector output; 1 = clear, 0 = collision.
- `pwm_l`, `pwm_r` out 1: registered PWM to the motor drivers.
- `dir_l`, `dir_r` out 1: registered direction; 1 = forward.
- `state` out 3: current FSM state code.
- `fault` out 1: latched when the retry limit is exceeded.

## Operation
- States: STOP=0, FWD=1, BRAKE=2, REVERSE=3, TURN=4. Codes 5–7 are illegal and go to STOP on the next edge.
- **Reset values:** state=STOP, pwm_l=pwm_r=0, dir_l=dir_r=1, fault=0, all counters 0.
- **Priority rule:** if `enable`=0 in any state, go to STOP on the next edge and clear the dwell timer, retry count and fault.
- **STOP:** duty 0, dirs 1. Go to FWD when enable=1, col_ok=1 and fault=0.
- **FWD:** dirs 1, duty target DUTY_FWD.
  - col_ok=0 → BRAKE.
  - Retry count clears after col_ok has stayed 1 for one full TURN_CYCLES in FWD.
- **BRAKE:** pwm forced 0, dirs unchanged. Lasts exactly BRAKE_CYCLES cycles, then REVERSE.
- **REVERSE:** dir_l=dir_r=0, duty target DUTY_MAN. Lasts exactly REVERSE_CYCLES cycles, then TURN.
- **TURN:** dir_l=1, dir_r=0, duty target DUTY_MAN. Lasts exactly TURN_CYCLES cycles. Retry count increments on exit, then:
  - col_ok=1 → FWD.
  - col_ok=0 and count < MAX_RETRY → BRAKE.
  - col_ok=0 and count = MAX_RETRY → STOP with fault=1.
- **Dwell timer:** counts 0..N−1 and the transition fires at N−1. It clears on every state change. col_ok is ignored during BRAKE, REVERSE and TURN.
- **PWM counter:** free-running, 0..PWM_PERIOD−1, wraps to 0. It is never reset by state changes.
- **Duty latch:** duty_active loads the state's duty target only on the wrap cycle (cnt = PWM_PERIOD−1), so every period is glitch-free.
- **PWM output:** pwm_x ← (state ∈ {FWD, REVERSE, TURN}) && (cnt < duty_active).
- **Widths:** counters are sized with $clog2 of their parameter. Compares are unsigned. Duty values ≥ PWM_PERIOD give constant high.

## Timing
- State updates one edge after the qualifying input.
- dir_x updates on the same edge as the state.
- pwm_x reflects the new state one edge later.
- Entering STOP or BRAKE forces pwm_x=0 on the edge after the state change, regardless of the PWM phase.
- A new non-zero duty takes effect from the first cnt=0 after entry. This gives a worst-case latency of PWM_PERIOD+1 cycles.
- `col_ok` is already synchronous to clk; no synchroniser is needed.
- rst mid-manoeuvre: next edge gives reset values, including STOP and fault=0.

## Configuration
- **`SOFT_START_EN` defined:** on each entry to FWD, duty_active starts at 0. At each wrap it adds RAMP_STEP, saturating at DUTY_FWD. REVERSE and TURN do not ramp.
- **`SOFT_START_EN` undefined:** duty_active takes DUTY_FWD at the first wrap after entry.

## Test plan
Bench parameters for all scenarios: PWM_PERIOD=10, DUTY_FWD=7, DUTY_MAN=5, BRAKE=4, REVERSE=20, TURN=12, MAX_RETRY=2, RAMP_STEP=3.
- **Reset and start:** rst for 3 cycles, then enable=1, col_ok=1 → state FWD next edge. From the first wrap, pwm high 7 of every 10 cycles; dirs 1.
- **Single collision:** col_ok=0 for 1 cycle in FWD → BRAKE. pwm=0 for exactly 4 cycles. REVERSE lasts 20 cycles with dirs 0/0 and duty 5. TURN lasts 12 cycles with dirs 1/0, then FWD.
- **Retry to fault:** col_ok held 0 throughout → two full manoeuvres, then STOP with fault=1 and pwm=0. Drop enable → fault=0. Re-enable with col_ok=1 → FWD.
- **Enable drop mid-REVERSE:** enable=0 at cycle 8 of REVERSE → STOP next edge; pwm 0 and dirs 1 one edge later.
- **Duty glitch-free:** collision at cnt=3 → no pwm pulse shorter than the programmed high time in any period.
- **Soft start (SOFT_START_EN):** enter FWD → per-period high-times 0, 3, 6, 7, 7.
